// File: rtl/seg_scan_capture.sv
// Receive-side capture of a multiplexed active-low 7-segment bus: synchronizes SEG/AN,
// waits for a stable pattern per digit, decodes it back to hex and tracks full-frame coverage.
module seg_scan_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [6:0]          i_seg,
  input  logic [NDIG-1:0]     i_an,
  output logic [4*NDIG-1:0]   o_digits,
  output logic [NDIG-1:0]     o_valid,
  output logic [NDIG-1:0]     o_err,
  output logic [NDIG-1:0]     o_blank,
  output logic                o_frame
);

  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  logic [6:0]          r_seg_meta, r_seg_sync;
  logic [NDIG-1:0]     r_an_meta, r_an_sync;
  logic [NDIG+6:0]     r_prev;
  logic [CW-1:0]       r_cnt;
  state_t              r_state;
  logic [NDIG-1:0]     r_seen;
  logic [4*NDIG-1:0]   r_digits;
  logic [NDIG-1:0]     r_valid, r_err, r_blank;
  logic                r_frame;

  logic [NDIG-1:0]     w_slot_mask;
  logic                w_qualified;
  logic                w_changed;
  logic [NDIG-1:0]     w_seen_next;
  logic [3:0]          w_cap_digit;
  logic                w_cap_valid, w_cap_err, w_cap_blank;

  // Returns {recognized, hex value} for an active-low segment pattern.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    case (seg)
      7'h40:   decodeSeg = {1'b1, 4'h0};
      7'h79:   decodeSeg = {1'b1, 4'h1};
      7'h24:   decodeSeg = {1'b1, 4'h2};
      7'h30:   decodeSeg = {1'b1, 4'h3};
      7'h19:   decodeSeg = {1'b1, 4'h4};
      7'h12:   decodeSeg = {1'b1, 4'h5};
      7'h02:   decodeSeg = {1'b1, 4'h6};
      7'h78:   decodeSeg = {1'b1, 4'h7};
      7'h00:   decodeSeg = {1'b1, 4'h8};
      7'h10:   decodeSeg = {1'b1, 4'h9};
      7'h08:   decodeSeg = {1'b1, 4'hA};
      7'h03:   decodeSeg = {1'b1, 4'hB};
      7'h46:   decodeSeg = {1'b1, 4'hC};
      7'h21:   decodeSeg = {1'b1, 4'hD};
      7'h06:   decodeSeg = {1'b1, 4'hE};
      7'h0E:   decodeSeg = {1'b1, 4'hF};
      default: decodeSeg = 5'b0_0000;
    endcase
  endfunction

  assign w_slot_mask = ~r_an_sync;
  assign w_qualified = $onehot(w_slot_mask);
  assign w_changed   = ({r_an_sync, r_seg_sync} != r_prev);
  assign w_seen_next = r_seen | w_slot_mask;

  always_comb begin
    logic [4:0] w_dec;
    w_dec       = decodeSeg(r_seg_sync);
    w_cap_digit = 4'h0;
    w_cap_valid = 1'b0;
    w_cap_err   = 1'b0;
    w_cap_blank = 1'b0;
    if (w_dec[4]) begin
      w_cap_digit = w_dec[3:0];
      w_cap_valid = 1'b1;
    end else if (r_seg_sync == 7'h7F) begin
      w_cap_blank = 1'b1;
    end else begin
      w_cap_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seg_meta <= 7'h7F;
      r_seg_sync <= 7'h7F;
      r_an_meta  <= '1;
      r_an_sync  <= '1;
      r_prev     <= {{NDIG{1'b1}}, 7'h7F};
      r_cnt      <= '0;
      r_state    <= IDLE;
      r_seen     <= '0;
      r_digits   <= '0;
      r_valid    <= '0;
      r_err      <= '0;
      r_blank    <= '0;
      r_frame    <= 1'b0;
    end else begin
      r_seg_meta <= i_seg;
      r_seg_sync <= r_seg_meta;
      r_an_meta  <= i_an;
      r_an_sync  <= r_an_meta;
      r_prev     <= {r_an_sync, r_seg_sync};
      r_frame    <= 1'b0;

      if (!w_qualified) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_changed) begin
              r_state <= TRACK;
              r_cnt   <= '0;
            end
          end
          TRACK: begin
            if (w_changed) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= HOLD;
              for (int i = 0; i < NDIG; i++) begin
                if (w_slot_mask[i]) begin
                  r_digits[4*i +: 4] <= w_cap_digit;
                  r_valid[i]         <= w_cap_valid;
                  r_err[i]           <= w_cap_err;
                  r_blank[i]         <= w_cap_blank;
                end
              end
              // Blank and error captures still count toward frame coverage.
              if (&w_seen_next) begin
                r_frame <= 1'b1;
                r_seen  <= '0;
              end else begin
                r_seen  <= w_seen_next;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (w_changed) begin
              r_state <= TRACK;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_digits = r_digits;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_blank  = r_blank;
  assign o_frame  = r_frame;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed, table-driven bench for seg_scan_capture with hand-written reset,
// glitch and mid-capture reset sequences.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rstN;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  valid, err, blank;
  logic        frame;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic [3:0]  blank;
    logic        frame;
  } vec_t;

  vec_t vecs[13];

  logic [15:0] pD;
  logic [3:0]  pV, pE, pB;

  seg_scan_capture #(.NDIG(4), .STABLE_CNT(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .i_seg    (seg),
    .i_an     (an),
    .o_digits (digits),
    .o_valid  (valid),
    .o_err    (err),
    .o_blank  (blank),
    .o_frame  (frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [15:0] d, input logic [3:0] v,
                          input logic [3:0] e, input logic [3:0] b, input logic f);
    checkOutput({tag, " digits"}, 32'(digits), 32'(d));
    checkOutput({tag, " valid"},  32'(valid),  32'(v));
    checkOutput({tag, " err"},    32'(err),    32'(e));
    checkOutput({tag, " blank"},  32'(blank),  32'(b));
    checkOutput({tag, " frame"},  32'(frame),  32'(f));
  endtask

  initial begin
    // Capture lands on the 11th edge after the pins change (edge N+10).
    vecs[0]  = '{4'b1110, 7'h30, 12, 16'h0003, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1110, 7'h12, 12, 16'h0005, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1101, 7'h08, 12, 16'h00A5, 4'b0011, 4'b0000, 4'b0000, 1'b0};
    vecs[3]  = '{4'b1011, 7'h46, 12, 16'h0CA5, 4'b0111, 4'b0000, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0111, 7'h00, 12, 16'h8CA5, 4'b1111, 4'b0000, 4'b0000, 1'b1};
    vecs[5]  = '{4'b1101, 7'h7E, 12, 16'h8C05, 4'b1101, 4'b0010, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1011, 7'h7F, 12, 16'h8005, 4'b1001, 4'b0010, 4'b0100, 1'b0};
    vecs[7]  = '{4'b1100, 7'h79, 20, 16'h8005, 4'b1001, 4'b0010, 4'b0100, 1'b0};
    vecs[8]  = '{4'b1110, 7'h79, 12, 16'h8001, 4'b1001, 4'b0010, 4'b0100, 1'b0};
    vecs[9]  = '{4'b0111, 7'h06, 12, 16'hE001, 4'b1001, 4'b0010, 4'b0100, 1'b1};
    vecs[10] = '{4'b1101, 7'h21, 12, 16'hE0D1, 4'b1011, 4'b0000, 4'b0100, 1'b0};
    vecs[11] = '{4'b1011, 7'h03, 12, 16'hEBD1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    vecs[12] = '{4'b1110, 7'h79, 12, 16'hEBD1, 4'b1111, 4'b0000, 4'b0000, 1'b0};

    rstN = 1'b0;
    applyStimulus(4'b1010, 7'h12);
    repeat (3) tick();
    checkAll("reset", 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'b1111, 7'h7F);
    rstN = 1'b1;
    repeat (3) tick();
    checkAll("idle", 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    pD = '0; pV = '0; pE = '0; pB = '0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].an, vecs[i].seg);
      repeat (10) tick();
      checkAll($sformatf("v%0d pre", i), pD, pV, pE, pB, 1'b0);
      tick();
      checkAll($sformatf("v%0d cap", i), vecs[i].digits, vecs[i].valid,
               vecs[i].err, vecs[i].blank, vecs[i].frame);
      for (int c = 11; c < vecs[i].hold; c++) tick();
      checkAll($sformatf("v%0d hold", i), vecs[i].digits, vecs[i].valid,
               vecs[i].err, vecs[i].blank, 1'b0);
      pD = vecs[i].digits; pV = vecs[i].valid; pE = vecs[i].err; pB = vecs[i].blank;
    end

    // Slot 0 shows 1; a 5-cycle glitch to 2 must never be captured.
    applyStimulus(4'b1110, 7'h24);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("glitch digit0", 32'(digits[3:0]), 32'h1);
      checkOutput("glitch frame", 32'(frame), 32'h0);
    end
    applyStimulus(4'b1110, 7'h79);
    for (int c = 0; c < 15; c++) begin
      tick();
      checkOutput("post-glitch digit0", 32'(digits[3:0]), 32'h1);
      checkOutput("post-glitch frame", 32'(frame), 32'h0);
    end
    checkAll("post-glitch", 16'hEBD1, 4'hF, 4'h0, 4'h0, 1'b0);

    // Reset while the counter sits at 5 aborts the capture of the 6 pattern.
    applyStimulus(4'b1110, 7'h02);
    repeat (8) tick();
    checkAll("pre-abort", 16'hEBD1, 4'hF, 4'h0, 4'h0, 1'b0);
    rstN = 1'b0;
    tick();
    checkAll("abort reset", 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rstN = 1'b1;
    repeat (10) tick();
    checkAll("abort pre", 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    checkAll("abort cap", 16'h0006, 4'b0001, 4'h0, 4'h0, 1'b0);
    tick();
    checkAll("abort hold", 16'h0006, 4'b0001, 4'h0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
